// File: rtl/jk_drive_sequencer.sv
// Command sequencer that drives a downstream JK latch through setup/pulse/settle
// phases, then checks the latch outputs against an internal expected-state model.
module jk_drive_sequencer #(
  parameter int PULSE_W = 1,
  parameter int SETTLE  = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       CmdValid,
  input  logic [1:0] CmdOp,
  output logic       CmdReady,
  output logic       J,
  output logic       K,
  output logic       En,
  input  logic       Q,
  input  logic       QN,
  output logic       Done,
  output logic       Err,
  output logic       ExpQ,
  output logic [7:0] ErrCount,
  output logic [2:0] state_dbg,
  output logic       exp_valid_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4
  } state_t;

  localparam logic [3:0] PULSE_LAST  = 4'(PULSE_W - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  // Handshake: a command is taken on a rising Clk edge where CmdValid && CmdReady;
  // CmdReady is high only in IDLE while out of reset, so CmdValid is ignored otherwise.

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [1:0] op_q, op_next;
  logic       exp_q, exp_q_next;
  logic       exp_valid, exp_valid_next;
  logic       drive;
  logic       j_next, k_next, en_next;
  logic       err_raw;

  assign CmdReady      = (state == ST_IDLE) && Rst_n;
  assign Done          = (state == ST_CHECK);
  assign err_raw       = (Q == QN) || (exp_valid && (Q != exp_q));
  assign Err           = (state == ST_CHECK) && err_raw;
  assign ExpQ          = exp_q;
  assign state_dbg     = state;
  assign exp_valid_dbg = exp_valid;

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    op_next        = op_q;
    exp_q_next     = exp_q;
    exp_valid_next = exp_valid;
    case (state)
      ST_IDLE: begin
        if (CmdValid) begin
          state_next = ST_SETUP;
          op_next    = CmdOp;
          // The expected-state model moves at SETUP entry, before the latch is pulsed.
          case (CmdOp)
            2'b10: begin
              exp_q_next     = 1'b1;
              exp_valid_next = 1'b1;
            end
            2'b01: begin
              exp_q_next     = 1'b0;
              exp_valid_next = 1'b1;
            end
            2'b11: begin
              if (exp_valid) exp_q_next = ~exp_q;
            end
            default: ;
          endcase
        end
      end
      ST_SETUP: begin
        state_next = ST_PULSE;
        cnt_next   = PULSE_LAST;
      end
      ST_PULSE: begin
        if (cnt == 4'd0) begin
          if (SETTLE == 0) begin
            state_next = ST_CHECK;
          end else begin
            state_next = ST_SETTLE;
            cnt_next   = SETTLE_LAST;
          end
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt == 4'd0) state_next = ST_CHECK;
        else             cnt_next   = cnt - 4'd1;
      end
      ST_CHECK: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    // J/K/En are registered from the next state so they line up with the phase.
    drive   = (state_next == ST_SETUP) || (state_next == ST_PULSE);
    j_next  = drive && op_next[1];
    k_next  = drive && op_next[0];
    en_next = (state_next == ST_PULSE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      op_q      <= 2'b00;
      exp_q     <= 1'b0;
      exp_valid <= 1'b0;
      J         <= 1'b0;
      K         <= 1'b0;
      En        <= 1'b0;
      ErrCount  <= 8'd0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      op_q      <= op_next;
      exp_q     <= exp_q_next;
      exp_valid <= exp_valid_next;
      J         <= j_next;
      K         <= k_next;
      En        <= en_next;
      if (Err && (ErrCount != 8'hFF)) ErrCount <= ErrCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Bench for jk_drive_sequencer: a JK latch environment, a command-level reference
// model, hand-checked vector table, multi-cycle corner sequences and random commands.
module tb_jk_drive_sequencer;

  localparam int PW = 1;
  localparam int ST = 2;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       CmdValid = 1'b0;
  logic [1:0] CmdOp = 2'b00;
  logic       CmdReady, J, K, En, Q, QN, Done, Err, ExpQ;
  logic [7:0] ErrCount;
  logic [2:0] state_dbg;
  logic       exp_valid_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  // Latch environment: 0 ideal, 1 stuck at Q=1/QN=0, 2 invalid Q=QN=1
  int   mode = 0;
  logic lq = 1'b0;

  // Command-level reference model
  logic m_exp_q = 1'b0;
  logic m_exp_valid = 1'b0;
  int   m_cnt = 0;

  jk_drive_sequencer #(.PULSE_W(PW), .SETTLE(ST)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .CmdValid(CmdValid), .CmdOp(CmdOp),
    .CmdReady(CmdReady), .J(J), .K(K), .En(En), .Q(Q), .QN(QN),
    .Done(Done), .Err(Err), .ExpQ(ExpQ), .ErrCount(ErrCount),
    .state_dbg(state_dbg), .exp_valid_dbg(exp_valid_dbg)
  );

  always #5 Clk = ~Clk;

  assign Q  = (mode == 0) ? lq : 1'b1;
  assign QN = (mode == 0) ? ~lq : ((mode == 1) ? 1'b0 : 1'b1);

  always @(posedge Clk) begin
    if (En === 1'b1) begin
      case ({J, K})
        2'b10:   lq <= 1'b1;
        2'b01:   lq <= 1'b0;
        2'b11:   lq <= ~lq;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_exp_q = 1'b0;
    m_exp_valid = 1'b0;
    m_cnt = 0;
  endtask

  // Reset for 2 clocks, checking the in-reset and first post-release values.
  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    CmdValid = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      chk("rst_j", J, 0);
      chk("rst_k", K, 0);
      chk("rst_en", En, 0);
      chk("rst_ready", CmdReady, 0);
      chk("rst_errcount", ErrCount, 0);
      chk("rst_done", Done, 0);
      chk("rst_expq", ExpQ, 0);
    end
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("ready_after_release", CmdReady, 1);
    chk("expvalid_after_release", exp_valid_dbg, 0);
    model_reset();
  endtask

  // One command, checked cycle by cycle against the phase timing and the model.
  task automatic run_cmd(input logic [1:0] op, output logic got_err,
                         output logic got_expq, output int got_cnt);
    int budget;
    logic err_e;
    budget = 0;
    got_err = 1'bx;
    got_expq = 1'bx;
    got_cnt = -1;
    while (CmdReady !== 1'b1 && budget < 50) begin
      @(negedge Clk);
      budget++;
    end
    if (CmdReady !== 1'b1) begin
      chk("ready_timeout", CmdReady, 1);
      return;
    end
    CmdValid = 1'b1;
    CmdOp = op;
    case (op)
      2'b10: begin m_exp_q = 1'b1; m_exp_valid = 1'b1; end
      2'b01: begin m_exp_q = 1'b0; m_exp_valid = 1'b1; end
      2'b11: if (m_exp_valid) m_exp_q = ~m_exp_q;
      default: ;
    endcase
    for (int c = 1; c <= 2 + PW + ST; c++) begin
      @(negedge Clk);
      if (c == 1) begin
        CmdValid = 1'b0;
        CmdOp = 2'($urandom_range(0, 3));
      end
      chk("ready_busy", CmdReady, 0);
      chk("en_phase", En, (c >= 2 && c <= 1 + PW) ? 1 : 0);
      chk("j_phase", J, (c <= 1 + PW) ? op[1] : 0);
      chk("k_phase", K, (c <= 1 + PW) ? op[0] : 0);
      chk("done_timing", Done, (c == 2 + PW + ST) ? 1 : 0);
      if (c == 2 + PW + ST) begin
        err_e = (Q == QN) || (m_exp_valid && (Q != m_exp_q));
        chk("err", Err, err_e);
        chk("expq", ExpQ, m_exp_q);
        chk("expvalid", exp_valid_dbg, m_exp_valid);
        got_err = Err;
        got_expq = ExpQ;
        if (err_e && m_cnt < 255) m_cnt++;
      end else begin
        chk("err_outside_check", Err, 0);
      end
    end
    @(negedge Clk);
    chk("errcount", ErrCount, m_cnt);
    chk("done_one_cycle", Done, 0);
    chk("ready_after_cmd", CmdReady, 1);
    got_cnt = int'(ErrCount);
  endtask

  typedef struct {
    logic [1:0] op;
    int         lmode;
    logic       exp_err;
    logic       exp_expq;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic ge, gq;
    int   gc;
    int   seen;

    vecs[0] = '{2'b10, 0, 1'b0, 1'b1, 0};  // set, ideal latch
    vecs[1] = '{2'b11, 0, 1'b0, 1'b0, 0};  // toggle back to 0
    vecs[2] = '{2'b10, 1, 1'b0, 1'b1, 0};  // set, latch stuck high
    vecs[3] = '{2'b11, 1, 1'b1, 1'b0, 1};  // toggle, stuck latch disagrees
    vecs[4] = '{2'b00, 2, 1'b1, 1'b0, 2};  // hold, Q==QN invalid
    vecs[5] = '{2'b01, 0, 1'b0, 1'b0, 2};  // reset
    vecs[6] = '{2'b11, 0, 1'b0, 1'b1, 2};  // toggle to 1
    vecs[7] = '{2'b00, 0, 1'b0, 1'b1, 2};  // hold

    do_reset();
    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].lmode;
      run_cmd(vecs[i].op, ge, gq, gc);
      chk($sformatf("vec%0d_err", i), ge, vecs[i].exp_err);
      chk($sformatf("vec%0d_expq", i), gq, vecs[i].exp_expq);
      chk($sformatf("vec%0d_cnt", i), gc, vecs[i].exp_cnt);
    end

    // Hold right after reset with invalid latch outputs
    mode = 0;
    do_reset();
    mode = 2;
    run_cmd(2'b00, ge, gq, gc);
    chk("hold_invalid_err", ge, 1);
    chk("hold_invalid_cnt", gc, 1);

    // CmdValid held: accepts every 3+PW+ST cycles
    mode = 0;
    do_reset();
    CmdValid = 1'b1;
    CmdOp = 2'b10;
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) @(negedge Clk);
      if (k == 15) CmdValid = 1'b0;
      if (k <= 14) chk($sformatf("b2b_ready_c%0d", k), CmdReady,
                       (k % (3 + PW + ST) == 0) ? 1 : 0);
      chk($sformatf("b2b_done_c%0d", k), Done,
          (k % (3 + PW + ST) == 2 + PW + ST) ? 1 : 0);
    end
    m_exp_q = 1'b1;
    m_exp_valid = 1'b1;
    @(negedge Clk);
    chk("b2b_errcount", ErrCount, 0);

    // Reset during PULSE abandons the command
    do_reset();
    CmdValid = 1'b1;
    CmdOp = 2'b10;
    @(negedge Clk);
    CmdValid = 1'b0;
    @(negedge Clk);
    chk("abort_en_in_pulse", En, 1);
    Rst_n = 1'b0;
    @(negedge Clk);
    chk("abort_en", En, 0);
    chk("abort_done", Done, 0);
    chk("abort_err", Err, 0);
    chk("abort_expvalid", exp_valid_dbg, 0);
    chk("abort_ready", CmdReady, 0);
    Rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge Clk);
      if (Done === 1'b1) seen++;
    end
    chk("abort_no_done", seen, 0);
    model_reset();

    // Randomized commands against the model
    for (int n = 0; n < 60; n++) begin
      mode = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      run_cmd(2'($urandom_range(0, 3)), ge, gq, gc);
    end

    // Saturation of the failure counter
    do_reset();
    mode = 2;
    for (int n = 0; n < 256; n++) begin
      run_cmd(2'($urandom_range(0, 3)), ge, gq, gc);
      if (n == 254) chk("errcount_255", gc, 255);
    end
    chk("errcount_saturated", ErrCount, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
